// File: rtl/threshold_command_gen.sv
// Operator-side writer for the HSV colour-reduction threshold registers.
// Debounces three buttons and emits single-cycle select/selector/inputVal writes.
module threshold_command_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_next,
  output logic       select,
  output logic [1:0] selector,
  output logic [2:0] inputVal,
  output logic [1:0] cur_channel,
  output logic [2:0] cur_bits
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StInitH, StInitS, StInitV, StIdle} state_e;

  state_e     state_q;
  logic [2:0] hue_q, sat_q, val_q;
  logic [2:0] btn_raw, sync1_q, sync2_q, db_lvl, db_prev_q, press;
  logic       wr_en;
  logic [2:0] wr_bits;

  // Bit order: [0] up, [1] down, [2] next
  assign btn_raw = {btn_next, btn_down, btn_up};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_prev_q <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_lvl;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic [CNT_W-1:0] cnt_q;
    logic             db_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
        db_q  <= 1'b0;
      end else if (sync2_q[g] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        cnt_q <= '0;
        db_q  <= ~db_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign db_lvl[g] = db_q;
  end

  assign press = db_lvl & ~db_prev_q;

  always_comb begin
    case (cur_channel)
      2'b00:   cur_bits = hue_q;
      2'b01:   cur_bits = sat_q;
      default: cur_bits = val_q;
    endcase
  end

  // A saturated up still swallows a simultaneous down: priority is next > up > down.
  always_comb begin
    wr_en   = 1'b0;
    wr_bits = cur_bits;
    if (state_q == StIdle && !press[2]) begin
      if (press[0]) begin
        if (cur_bits != 3'd7) begin
          wr_en   = 1'b1;
          wr_bits = cur_bits + 3'd1;
        end
      end else if (press[1] && cur_bits != 3'd1) begin
        wr_en   = 1'b1;
        wr_bits = cur_bits - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StInitH;
      select      <= 1'b0;
      selector    <= 2'b00;
      inputVal    <= 3'd0;
      cur_channel <= 2'b00;
      hue_q       <= 3'd3;
      sat_q       <= 3'd2;
      val_q       <= 3'd2;
    end else begin
      select <= 1'b0;
      case (state_q)
        StInitH: begin
          select   <= 1'b1;
          selector <= 2'b00;
          inputVal <= hue_q;
          state_q  <= StInitS;
        end
        StInitS: begin
          select   <= 1'b1;
          selector <= 2'b01;
          inputVal <= sat_q;
          state_q  <= StInitV;
        end
        StInitV: begin
          select   <= 1'b1;
          selector <= 2'b10;
          inputVal <= val_q;
          state_q  <= StIdle;
        end
        StIdle: begin
          if (press[2]) begin
            cur_channel <= (cur_channel == 2'b10) ? 2'b00 : cur_channel + 2'd1;
          end
          if (wr_en) begin
            select   <= 1'b1;
            selector <= cur_channel;
            inputVal <= wr_bits;
            case (cur_channel)
              2'b00:   hue_q <= wr_bits;
              2'b01:   sat_q <= wr_bits;
              default: val_q <= wr_bits;
            endcase
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_threshold_command_gen.sv
// Bench for threshold_command_gen: directed cases plus random presses
// checked against a per-press model of channel and bit counts.
module tb_threshold_command_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_next = 1'b0;
  logic       select;
  logic [1:0] selector;
  logic [2:0] inputVal;
  logic [1:0] cur_channel;
  logic [2:0] cur_bits;

  int checks = 0;
  int errors = 0;
  int m_cnt[3];
  int m_ch;

  threshold_command_gen #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_next   (btn_next),
    .select     (select),
    .selector   (selector),
    .inputVal   (inputVal),
    .cur_channel(cur_channel),
    .cur_bits   (cur_bits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt[0] = 3;
    m_cnt[1] = 2;
    m_cnt[2] = 2;
    m_ch     = 0;
  endtask

  // Called at a negedge with reset low; releases reset and checks the three init writes.
  task automatic init_seq(input string tag);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("%s_sel%0d", tag, k), select, 1);
      chk($sformatf("%s_selector%0d", tag, k), selector, k);
      chk($sformatf("%s_val%0d", tag, k), inputVal, m_cnt[k]);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("%s_quiet%0d", tag, k), select, 0);
    end
    chk({tag, "_ch"}, cur_channel, 0);
    chk({tag, "_bits"}, cur_bits, 3);
  endtask

  // One clean press of the given buttons; expects at most one strobe over the whole window.
  task automatic press(input bit nxt, input bit up, input bit dn, input int hold,
                       input string tag);
    int         ns;
    logic [1:0] ls;
    logic [2:0] lv;
    bit         exp_str;
    exp_str = 1'b0;
    if (nxt) begin
      m_ch = (m_ch + 1) % 3;
    end else if (up) begin
      if (m_cnt[m_ch] < 7) begin
        m_cnt[m_ch]++;
        exp_str = 1'b1;
      end
    end else if (dn) begin
      if (m_cnt[m_ch] > 1) begin
        m_cnt[m_ch]--;
        exp_str = 1'b1;
      end
    end
    ns = 0;
    ls = 'x;
    lv = 'x;
    btn_next = nxt;
    btn_up   = up;
    btn_down = dn;
    for (int i = 0; i < hold + 16; i++) begin
      @(negedge clk);
      if (select === 1'b1) begin
        ns++;
        ls = selector;
        lv = inputVal;
      end
      if (i == hold - 1) begin
        btn_next = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
      end
    end
    chk({tag, "_strobes"}, ns, exp_str);
    if (exp_str) begin
      chk({tag, "_selector"}, ls, m_ch);
      chk({tag, "_val"}, lv, m_cnt[m_ch]);
    end
    chk({tag, "_ch"}, cur_channel, m_ch);
    chk({tag, "_bits"}, cur_bits, m_cnt[m_ch]);
  endtask

  initial begin
    int ns;
    int op;
    int hold;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_select", select, 0);
    chk("rst_selector", selector, 0);
    chk("rst_inputval", inputVal, 0);
    chk("rst_ch", cur_channel, 0);
    chk("rst_bits", cur_bits, 3);
    init_seq("init");

    // Bounces shorter than the debounce window must not register
    ns = 0;
    for (int i = 0; i < 20; i++) begin
      btn_up = ((i / 2) % 2 == 0);
      @(negedge clk);
      if (select === 1'b1) ns++;
    end
    btn_up = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (select === 1'b1) ns++;
    end
    chk("bounce_strobes", ns, 0);
    chk("bounce_bits", cur_bits, 3);

    press(0, 1, 0, 10, "up_clean");
    press(1, 0, 0, 8, "next_a");
    press(0, 0, 1, 8, "down_a");
    press(0, 0, 1, 8, "down_sat");
    press(1, 0, 0, 6, "next_b");
    chk("next_b_pass_v", cur_channel, 2);
    press(1, 0, 0, 6, "next_c");
    chk("next_c_pass_h", cur_channel, 0);
    press(1, 0, 0, 6, "next_d");
    press(1, 0, 0, 6, "next_e");
    press(1, 0, 0, 6, "next_f");
    press(0, 1, 0, 7, "up_5");
    press(0, 1, 0, 7, "up_6");
    press(0, 1, 0, 7, "up_7");
    press(0, 1, 0, 7, "up_sat");
    press(1, 1, 0, 8, "up_next");
    press(1, 0, 0, 6, "next_g");
    press(1, 0, 0, 6, "next_h");
    press(0, 0, 1, 7, "down_6");
    press(0, 0, 1, 7, "down_5");

    // Reset mid-debounce with hue at 5
    btn_up = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_select", select, 0);
    chk("arst_selector", selector, 0);
    chk("arst_inputval", inputVal, 0);
    chk("arst_ch", cur_channel, 0);
    chk("arst_bits", cur_bits, 3);
    btn_up = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    init_seq("rst2");

    for (int i = 0; i < 30; i++) begin
      op   = $urandom_range(0, 2);
      hold = $urandom_range(5, 12);
      press(op == 2, op == 0, op == 1, hold, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
